// File: rtl/adc_oversample_filter_pkg.sv
// ---------------------------------------------------------------------------
// adc_oversample_filter_pkg
//   Shared definitions for the ADC oversampling filter: the default sample,
//   channel and oversample-exponent widths (shared with the ADC controller and
//   the PID core), the filter FSM state encoding, and width helpers.
// ---------------------------------------------------------------------------
package adc_oversample_filter_pkg;

    // Default widths shared across the ADC -> filter -> PID datapath.
    localparam int ADC_W_DATA = 18;
    localparam int ADC_N_CHAN = 8;
    localparam int ADC_W_CHAN = 3;
    localparam int ADC_W_OSR  = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ovs_state_t;

    // Window counter width: holds up to 2^(2^w_osr - 1) - 1.
    function automatic int ovs_cnt_width(input int w_osr);
        return (1 << w_osr) - 1;
    endfunction

    // Accumulator width: sample width plus one bit per doubling of the window.
    function automatic int ovs_acc_width(input int w_data, input int w_osr);
        return w_data + ovs_cnt_width(w_osr);
    endfunction

endpackage

// File: rtl/adc_oversample_filter_if.sv
// ---------------------------------------------------------------------------
// adc_oversample_filter_if
//   Sample-stream bundle around the oversampling filter.
//   Input side : dv_in (strobe), chan_in, data_in (signed), os_in (exponent)
//   Output side: dv_out (strobe), chan_out, data_out (signed average)
//   Modports:
//     slave  - the filter's view (consumes *_in, drives *_out)
//     master - the upstream/downstream environment's view
// ---------------------------------------------------------------------------
interface adc_oversample_filter_if
    import adc_oversample_filter_pkg::*;
#(
    parameter int W_DATA = ADC_W_DATA,
    parameter int W_CHAN = ADC_W_CHAN,
    parameter int W_OSR  = ADC_W_OSR
);
    logic                     dv_in;
    logic [W_CHAN-1:0]        chan_in;
    logic signed [W_DATA-1:0] data_in;
    logic [W_OSR-1:0]         os_in;
    logic                     dv_out;
    logic [W_CHAN-1:0]        chan_out;
    logic signed [W_DATA-1:0] data_out;

    modport slave (
        input  dv_in, chan_in, data_in, os_in,
        output dv_out, chan_out, data_out
    );

    modport master (
        output dv_in, chan_in, data_in, os_in,
        input  dv_out, chan_out, data_out
    );
endinterface

// File: rtl/adc_oversample_filter_chan_acc.sv
// ---------------------------------------------------------------------------
// ovs_chan_acc
//   One channel's boxcar accumulator and window counter.
//   Ports:
//     clk_in, reset_in : clock, asynchronous active-high reset
//     clr_in           : zero accumulator and counter
//     add_in           : accumulate data_in; on the last sample of the window
//                        the state is cleared instead of stored
//     data_in          : signed sample
//     cnt_max_in       : 2^os - 1, index of the last sample in a window
//     sum_out          : acc + sext(data_in), combinational
//     last_out         : the next added sample completes the window
// ---------------------------------------------------------------------------
module ovs_chan_acc #(
    parameter int W_DATA = 18,
    parameter int W_ACC  = 33,
    parameter int W_CNT  = 15
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     clr_in,
    input  logic                     add_in,
    input  logic signed [W_DATA-1:0] data_in,
    input  logic [W_CNT-1:0]         cnt_max_in,
    output logic signed [W_ACC-1:0]  sum_out,
    output logic                     last_out
);
    logic signed [W_ACC-1:0] acc_q, acc_d;
    logic [W_CNT-1:0]        cnt_q, cnt_d;

    always_comb begin
        sum_out  = acc_q + {{(W_ACC-W_DATA){data_in[W_DATA-1]}}, data_in};
        last_out = (cnt_q == cnt_max_in);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        // A completed window is emitted by the parent, so the channel restarts
        // empty rather than storing the final sum.
        if (clr_in || (add_in && last_out)) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_in) begin
            acc_d = sum_out;
            cnt_d = cnt_q + W_CNT'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/adc_oversample_filter.sv
// ---------------------------------------------------------------------------
// adc_oversample_filter
//   Per-channel boxcar oversampling filter. Accumulates 2^os_in samples per
//   channel and emits one averaged sample per completed window, one cycle
//   after the sample that completes it. Changing os_in restarts all windows
//   after one dead clear cycle.
//   Ports:
//     clk_in   : system clock
//     reset_in : asynchronous active-high reset
//     bus      : adc_oversample_filter_if.slave (dv/chan/data in, os_in,
//                dv/chan/data out)
//   Build option:
//     ADC_OVS_ROUND_EN : round half up (add 2^(os-1) before the shift);
//                        when undefined the average is floored.
// ---------------------------------------------------------------------------
module adc_oversample_filter
    import adc_oversample_filter_pkg::*;
#(
    parameter int W_DATA = ADC_W_DATA,
    parameter int N_CHAN = ADC_N_CHAN,
    parameter int W_CHAN = ADC_W_CHAN,
    parameter int W_OSR  = ADC_W_OSR
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    adc_oversample_filter_if.slave bus
);
    localparam int W_CNT = ovs_cnt_width(W_OSR);
    localparam int W_ACC = ovs_acc_width(W_DATA, W_OSR);

    ovs_state_t               state_q, state_d;
    logic [W_OSR-1:0]         os_reg_q, os_reg_d;
    logic                     dv_out_q, dv_out_d;
    logic [W_CHAN-1:0]        chan_out_q, chan_out_d;
    logic signed [W_DATA-1:0] data_out_q, data_out_d;

    logic [N_CHAN-1:0]        chan_hit;
    logic [N_CHAN-1:0]        add_vec;
    logic [N_CHAN-1:0]        last_vec;
    logic signed [W_ACC-1:0]  sum_arr [N_CHAN];

    logic                     clr_all;
    logic                     accept;
    logic                     sel_last;
    logic [W_CNT-1:0]         cnt_max;
    logic signed [W_ACC-1:0]  sum_sel;
    logic signed [W_ACC-1:0]  rnd;
    logic signed [W_ACC-1:0]  rounded;
    logic signed [W_ACC-1:0]  shifted;

    // Per-channel decode; a channel index with no matching lane leaves
    // chan_hit all-zero, so out-of-range samples never touch any state.
    generate
        for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
            assign chan_hit[gi] = (bus.chan_in == W_CHAN'(gi));
            assign add_vec[gi]  = accept & chan_hit[gi];

            ovs_chan_acc #(
                .W_DATA (W_DATA),
                .W_ACC  (W_ACC),
                .W_CNT  (W_CNT)
            ) u_acc (
                .clk_in     (clk_in),
                .reset_in   (reset_in),
                .clr_in     (clr_all),
                .add_in     (add_vec[gi]),
                .data_in    (bus.data_in),
                .cnt_max_in (cnt_max),
                .sum_out    (sum_arr[gi]),
                .last_out   (last_vec[gi])
            );
        end
    endgenerate

    // Select the addressed channel's running sum and end-of-window flag.
    always_comb begin
        sum_sel  = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (chan_hit[i]) begin
                sum_sel  = sum_arr[i];
                sel_last = last_vec[i];
            end
        end
    end

    always_comb begin
        cnt_max = W_CNT'((32'd1 << os_reg_q) - 32'd1);
    end

    // FSM: ST_CLEAR empties every window and latches the exponent; ST_RUN
    // accumulates until the exponent input moves away from the latched copy.
    always_comb begin
        state_d  = state_q;
        os_reg_d = os_reg_q;
        clr_all  = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_all  = 1'b1;
                os_reg_d = bus.os_in;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (bus.os_in != os_reg_q) begin
                    state_d = ST_CLEAR;
                end else begin
                    accept = bus.dv_in && (|chan_hit);
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_comb begin
`ifdef ADC_OVS_ROUND_EN
        if (os_reg_q != '0) begin
            rnd = W_ACC'(1) << (os_reg_q - W_OSR'(1));
        end else begin
            rnd = '0;
        end
`else
        rnd = '0;
`endif
        rounded    = sum_sel + rnd;
        shifted    = rounded >>> os_reg_q;
        dv_out_d   = 1'b0;
        chan_out_d = chan_out_q;
        data_out_d = data_out_q;
        if (accept && sel_last) begin
            dv_out_d   = 1'b1;
            chan_out_d = bus.chan_in;
            // The average of W_DATA-bit samples always fits in W_DATA bits.
            data_out_d = W_DATA'(shifted);
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_CLEAR;
            os_reg_q   <= '0;
            dv_out_q   <= 1'b0;
            chan_out_q <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            os_reg_q   <= os_reg_d;
            dv_out_q   <= dv_out_d;
            chan_out_q <= chan_out_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.dv_out   = dv_out_q;
    assign bus.chan_out = chan_out_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_adc_oversample_filter.sv
module tb_adc_oversample_filter;
    import adc_oversample_filter_pkg::*;

`ifdef ADC_OVS_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    adc_oversample_filter_if bus ();

    adc_oversample_filter dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare outputs; channel/data are only meaningful on a strobe.
    task automatic expect_out(input string tag, input logic edv,
                              input int ech, input int edat);
        chk({tag, ".dv"}, {31'd0, bus.dv_out}, {31'd0, edv});
        if (edv) begin
            chk({tag, ".chan"}, {29'd0, bus.chan_out}, ech);
            chk({tag, ".data"}, 32'(bus.data_out), edat);
        end
        $display("[TB] %s dv=%0d chan=%0d data=%0d", tag, bus.dv_out,
                 bus.chan_out, bus.data_out);
    endtask

    // Drive one cycle of input (from a negedge) and return at the next
    // negedge, when the registered outputs for that cycle are visible.
    task automatic cyc(input logic dv, input logic [2:0] ch, input int d);
        bus.dv_in   = dv;
        bus.chan_in = ch;
        bus.data_in = 18'(d);
        @(negedge clk);
        bus.dv_in   = 1'b0;
    endtask

    task automatic set_os(input logic [3:0] v);
        bus.os_in = v;
        cyc(1'b0, 3'd0, 0);
        cyc(1'b0, 3'd0, 0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.dv_in   = 1'b0;
        bus.chan_in = '0;
        bus.data_in = '0;
        bus.os_in   = '0;
        repeat (2) @(negedge clk);
        chk("reset.dv", {31'd0, bus.dv_out}, 32'sd0);
        chk("reset.chan", {29'd0, bus.chan_out}, 32'sd0);
        chk("reset.data", 32'(bus.data_out), 32'sd0);
        rst = 1'b0;
        cyc(1'b0, 3'd0, 0);                       // clear cycle

        // Passthrough
        cyc(1'b1, 3'd3, -5);
        expect_out("pass", 1'b1, 3, -5);
        cyc(1'b0, 3'd0, 0);
        expect_out("pass_idle", 1'b0, 0, 0);
        chk("pass_hold", 32'(bus.data_out), -32'sd5);

        // Average of 4, same channel back-to-back
        set_os(4'd2);
        expect_out("os2_dead", 1'b0, 0, 0);
        cyc(1'b1, 3'd0, 10);
        expect_out("avg4_s1", 1'b0, 0, 0);
        cyc(1'b1, 3'd0, 11);
        cyc(1'b1, 3'd0, 12);
        expect_out("avg4_s3", 1'b0, 0, 0);
        cyc(1'b1, 3'd0, 14);
        expect_out("avg4", 1'b1, 0, RND ? 12 : 11);

        // Interleave two channels
        set_os(4'd1);
        cyc(1'b1, 3'd0, 100);
        expect_out("il_s1", 1'b0, 0, 0);
        cyc(1'b1, 3'd4, -100);
        expect_out("il_s2", 1'b0, 0, 0);
        cyc(1'b1, 3'd0, 102);
        expect_out("il_ch0", 1'b1, 0, 101);
        cyc(1'b1, 3'd4, -103);
        expect_out("il_ch4", 1'b1, 4, RND ? -101 : -102);
        cyc(1'b0, 3'd0, 0);
        expect_out("il_idle", 1'b0, 0, 0);

        // Negative floor
        cyc(1'b1, 3'd2, -1);
        cyc(1'b1, 3'd2, -2);
        expect_out("negfloor", 1'b1, 2, RND ? -1 : -2);

        // Exponent change mid-window
        set_os(4'd3);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 3'd1, i);
        expect_out("osc_partial", 1'b0, 0, 0);
        bus.os_in = 4'd1;
        cyc(1'b1, 3'd1, 999);                     // discarded: change seen
        expect_out("osc_disc", 1'b0, 0, 0);
        cyc(1'b1, 3'd1, 999);                     // discarded: clear cycle
        expect_out("osc_clear", 1'b0, 0, 0);
        cyc(1'b1, 3'd1, 20);
        expect_out("osc_s1", 1'b0, 0, 0);
        cyc(1'b1, 3'd1, 31);
        expect_out("osc_mean", 1'b1, 1, RND ? 26 : 25);

        // Reset mid-window
        set_os(4'd2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'd5, 1000);
        expect_out("rst_partial", 1'b0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async.dv", {31'd0, bus.dv_out}, 32'sd0);
        chk("rst_async.chan", {29'd0, bus.chan_out}, 32'sd0);
        chk("rst_async.data", 32'(bus.data_out), 32'sd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 3'd0, 0);                       // clear cycle, loads os=2
        cyc(1'b1, 3'd5, 4);
        cyc(1'b1, 3'd5, 5);
        cyc(1'b1, 3'd5, 6);
        expect_out("rst_s3", 1'b0, 0, 0);
        cyc(1'b1, 3'd5, 8);
        expect_out("rst_avg", 1'b1, 5, RND ? 6 : 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
